// File: rtl/mem_play_ctrl.sv
// mem_play_ctrl: APB-configured playback scheduler for the 128x12 SPI test memory.
// Fetches BASE..BASE+LEN-1 (7-bit wrap), presents each word to the SPI engine with a
// valid/next handshake, optionally repeats or loops, and reports busy/done/abort status.
module mem_play_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        mem_rden,
  output logic [6:0]  mem_raddr,
  input  logic [11:0] mem_rdata,
  output logic        spi_en,
  output logic        spi_valid,
  output logic [11:0] spi_data,
  input  logic        spi_next,
  output logic        irq_done
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_PRESENT, S_GAP} state_t;

  state_t      r_state;
  logic        r_pready;
  logic [6:0]  r_base;
  logic [7:0]  r_len;
  logic [7:0]  r_repeat;
  logic [15:0] r_gap;
  logic        r_loop;
  logic [7:0]  r_idx;
  logic [7:0]  r_pass;
  logic [15:0] r_gcnt;
  logic        r_done;
  logic        r_aborted;
  logic        r_mem_rden;
  logic [6:0]  r_mem_raddr;
  logic        r_spi_valid;
  logic [11:0] r_spi_data;
  logic        r_irq;

  logic        w_wr;
  logic        w_busy;
  logic        w_ctrl_wr;
  logic        w_abort;
  logic        w_start;
  logic [7:0]  w_idx_inc;
  logic        w_last;
  logic        w_again;
  logic [6:0]  w_cur_addr;
  logic        w_unused;

  assign w_wr       = psel & penable & pwrite & ~r_pready;
  assign w_busy     = (r_state != S_IDLE);
  assign w_ctrl_wr  = w_wr & (paddr[7:0] == 8'h00);
  assign w_abort    = w_ctrl_wr & pwdata[1];
  assign w_start    = w_ctrl_wr & pwdata[0] & ~pwdata[1] & ~w_busy;
  assign w_idx_inc  = r_idx + 8'd1;
  assign w_last     = (w_idx_inc == r_len);
  assign w_again    = r_loop | (r_pass != 8'd0);
  assign w_cur_addr = r_base + r_idx[6:0];
  assign w_unused   = ^{paddr[31:8], pwdata[31:16]};

  assign pready    = r_pready;
  assign pslverr   = 1'b0;
  assign mem_rden  = r_mem_rden;
  assign mem_raddr = r_mem_raddr;
  assign spi_en    = w_busy;
  assign spi_valid = r_spi_valid;
  assign spi_data  = r_spi_data;
  assign irq_done  = r_irq;

  // APB handshake and configuration registers; config is frozen while a session runs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pready <= 1'b0;
      r_base   <= '0;
      r_len    <= '0;
      r_repeat <= '0;
      r_gap    <= '0;
      r_loop   <= 1'b0;
    end else begin
      r_pready <= psel & penable & ~r_pready;
      if (w_wr && !w_busy) begin
        case (paddr[7:0])
          8'h00: r_loop   <= pwdata[2];
          8'h04: r_base   <= pwdata[6:0];
          8'h08: r_len    <= (pwdata[7:0] > 8'd128) ? 8'd128 : pwdata[7:0];
          8'h0C: r_repeat <= pwdata[7:0];
          8'h10: r_gap    <= pwdata[15:0];
          default: ;
        endcase
      end
    end
  end

  // Playback FSM with registered memory strobe, SPI word and completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_pass      <= '0;
      r_gcnt      <= '0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_mem_rden  <= 1'b0;
      r_mem_raddr <= '0;
      r_spi_valid <= 1'b0;
      r_spi_data  <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      if (w_abort) begin
        r_state     <= S_IDLE;
        r_spi_valid <= 1'b0;
        r_mem_rden  <= 1'b0;
        r_aborted   <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              if (r_len == 8'd0) begin
                r_done <= 1'b1;
                r_irq  <= 1'b1;
              end else begin
                r_idx       <= '0;
                r_pass      <= r_repeat;
                r_done      <= 1'b0;
                r_aborted   <= 1'b0;
                r_state     <= S_RD;
                r_mem_rden  <= 1'b1;
                r_mem_raddr <= r_base;
              end
            end
          end
          S_RD: begin
            r_mem_rden <= 1'b0;
            r_state    <= S_WAIT;
          end
          S_WAIT: begin
            r_spi_data  <= mem_rdata;
            r_spi_valid <= 1'b1;
            r_state     <= S_PRESENT;
          end
          S_PRESENT: begin
            if (spi_next) begin
              r_spi_valid <= 1'b0;
              if (!w_last || w_again) begin
                // wrapping to a new pass restarts at BASE; otherwise step to the next word
                if (!w_last) begin
                  r_idx <= w_idx_inc;
                end else begin
                  r_idx <= '0;
                  if (r_pass != 8'd0) r_pass <= r_pass - 8'd1;
                end
                if (r_gap != 16'd0) begin
                  r_state <= S_GAP;
                  r_gcnt  <= r_gap - 16'd1;
                end else begin
                  r_state     <= S_RD;
                  r_mem_rden  <= 1'b1;
                  r_mem_raddr <= r_base + (w_last ? 7'd0 : w_idx_inc[6:0]);
                end
              end else begin
                r_idx   <= w_idx_inc;
                r_state <= S_IDLE;
                r_done  <= 1'b1;
                r_irq   <= 1'b1;
              end
            end
          end
          S_GAP: begin
            if (r_gcnt == 16'd0) begin
              r_state     <= S_RD;
              r_mem_rden  <= 1'b1;
              r_mem_raddr <= w_cur_addr;
            end else begin
              r_gcnt <= r_gcnt - 16'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // APB read mux, combinational from the address
  always_comb begin
    prdata = '0;
    case (paddr[7:0])
      8'h00: prdata = {29'd0, r_loop, 2'b00};
      8'h04: prdata = {25'd0, r_base};
      8'h08: prdata = {24'd0, r_len};
      8'h0C: prdata = {24'd0, r_repeat};
      8'h10: prdata = {16'd0, r_gap};
      8'h14: prdata = {8'd0, r_pass, 1'b0, w_cur_addr, 5'd0, r_aborted, r_done, w_busy};
      default: prdata = '0;
    endcase
  end

endmodule
